// File: rtl/exe_pkg.sv
// exe_pkg: ALU command codes, shifter types, NZCV bit positions and multiplier FSM states.
package exe_pkg;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;
endpackage

// File: rtl/exe_val2_gen.sv
// exe_val2_gen: second-operand generator (rotated imm8, memory offset, or shifted val_rm).
module exe_val2_gen
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            imm,
  input  logic            mem,
  input  logic [11:0]     shift_operand,
  input  logic [XLEN-1:0] val_rm,
  output logic [XLEN-1:0] val2
);
  logic [31:0] imm8, imm32;
  logic [4:0] rot, amt;
  logic [XLEN-1:0] asr, shifted;
  assign imm8 = {24'h0, shift_operand[7:0]};
  assign rot = {shift_operand[11:8], 1'b0};
  // immediate rotation is always 32-bit wide, then zero-extended
  assign imm32 = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
  assign amt = shift_operand[11:7];
  assign asr = $signed(val_rm) >>> amt;
  assign shifted = (shift_operand[6:5] == SH_LSL) ? val_rm << amt
                 : (shift_operand[6:5] == SH_LSR) ? val_rm >> amt
                 : (shift_operand[6:5] == SH_ASR) ? asr
                 : (val_rm >> amt) | (val_rm << (7'(XLEN) - {2'b0, amt}));
  assign val2 = imm ? XLEN'(imm32) : mem ? XLEN'(shift_operand) : shifted;
endmodule

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: handshaked ARM execute stage (Val2, ALU, NZCV, branch target, EXE/MEM register).
// Define EXE_MUL_EN to add the iterative shift-add multiplier for MUL (1010).
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      exe_cmd,
  input  logic            mem_r_en,
  input  logic            mem_w_en,
  input  logic            wb_en,
  input  logic            s_bit,
  input  logic            b_en,
  input  logic [3:0]      dest,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] val_rn,
  input  logic [XLEN-1:0] val_rm,
  input  logic            imm,
  input  logic [11:0]     shift_operand,
  input  logic [23:0]     signed_imm_24,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_val_rm,
  output logic [3:0]      out_dest,
  output logic            out_mem_r_en,
  output logic            out_mem_w_en,
  output logic            out_wb_en,
  output logic            br_taken,
  output logic [XLEN-1:0] br_addr,
  output logic [3:0]      sr
);
  logic [XLEN-1:0] val2, res, ld_res, ld_rm;
  logic [XLEN:0] sum;
  logic [3:0] nzcv, ld_dest, sr_d;
  logic [2:0] ld_ctl;
  logic arith, sub, known, is_mul, busy, accept, load_alu, mul_load, slot_free, ld, sr_we;

  if ((XLEN != 32 && XLEN != 64) || XLEN % MUL_STEP != 0) begin : g_bad_cfg
    $error("exe_stage_pipe: illegal XLEN/MUL_STEP combination");
  end

  exe_val2_gen #(.XLEN(XLEN)) u_val2 (
    .imm(imm),
    .mem(mem_r_en | mem_w_en),
    .shift_operand(shift_operand),
    .val_rm(val_rm),
    .val2(val2)
  );

  assign slot_free = !out_valid || out_ready;
  assign in_ready = !busy && slot_free;
  assign accept = in_valid && in_ready && !flush;
  assign load_alu = accept && !is_mul;
  assign arith = exe_cmd inside {CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC};
  assign sub = exe_cmd inside {CMD_SUB, CMD_SBC};
  // subtract as rn + ~val2 + carry so the carry out is directly ARM's not-borrow
  assign sum = {1'b0, val_rn} + {1'b0, sub ? ~val2 : val2}
             + {{XLEN{1'b0}}, exe_cmd == CMD_SUB || (exe_cmd inside {CMD_ADC, CMD_SBC} && sr[SR_C])};

  always_comb begin
    res = '0;
    known = 1'b1;
    case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[XLEN-1:0];
      CMD_AND: res = val_rn & val2;
      CMD_ORR: res = val_rn | val2;
      CMD_EOR: res = val_rn ^ val2;
      default: known = 1'b0;
    endcase
  end

  assign nzcv = {res[XLEN-1], res == '0, arith ? sum[XLEN] : sr[SR_C],
                 arith ? (val_rn[XLEN-1] == (val2[XLEN-1] ^ sub)) && (res[XLEN-1] != val_rn[XLEN-1]) : sr[SR_V]};

`ifdef EXE_MUL_EN
  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW = $clog2(STEPS + 1);
  mul_state_t state, state_n;
  logic [XLEN-1:0] m_acc, m_mcand, m_mplier, m_rm;
  logic [CW-1:0] m_cnt;
  logic [3:0] m_dest;
  logic [2:0] m_ctl;
  logic m_s;
  assign is_mul = exe_cmd == CMD_MUL && !b_en;

  always_ff @(posedge clk)
    if (rst) state <= M_IDLE;
    else state <= state_n;

  always_comb
    state_n = flush ? M_IDLE
            : (state == M_IDLE && accept && is_mul) ? M_BUSY
            : (state == M_BUSY && m_cnt == CW'(1)) ? M_DONE
            : (state == M_DONE && slot_free) ? M_IDLE
            : state;

  always_comb begin
    busy = state != M_IDLE;
    mul_load = state == M_DONE && slot_free && !flush;
  end

  // retire MUL_STEP multiplier bits per cycle into the accumulator
  always_ff @(posedge clk)
    if (accept && is_mul) begin
      m_acc <= '0;
      m_mcand <= val_rn;
      m_mplier <= val2;
      m_cnt <= CW'(STEPS);
      m_rm <= val_rm;
      m_dest <= dest;
      m_ctl <= {mem_r_en, mem_w_en, wb_en};
      m_s <= s_bit;
    end else if (state == M_BUSY) begin
      m_acc <= m_acc + m_mcand * XLEN'(m_mplier[MUL_STEP-1:0]);
      m_mcand <= m_mcand << MUL_STEP;
      m_mplier <= m_mplier >> MUL_STEP;
      m_cnt <= m_cnt - CW'(1);
    end
`else
  assign is_mul = 1'b0;
  assign busy = 1'b0;
  assign mul_load = 1'b0;
`endif

  always_comb begin
    ld = load_alu;
    ld_res = res;
    ld_rm = val_rm;
    ld_dest = dest;
    ld_ctl = b_en ? 3'b000 : {mem_r_en, mem_w_en, wb_en};
    sr_we = load_alu && s_bit && known && !b_en;
    sr_d = nzcv;
`ifdef EXE_MUL_EN
    if (mul_load) begin
      ld = 1'b1;
      ld_res = m_acc;
      ld_rm = m_rm;
      ld_dest = m_dest;
      ld_ctl = m_ctl;
      sr_we = m_s;
      sr_d = {m_acc[XLEN-1], m_acc == '0, sr[SR_C], sr[SR_V]};
    end
`endif
  end

  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_alu_result <= '0;
      out_val_rm <= '0;
      out_dest <= '0;
      {out_mem_r_en, out_mem_w_en, out_wb_en} <= 3'b000;
      br_taken <= 1'b0;
      br_addr <= '0;
      sr <= '0;
    end else begin
      out_valid <= !flush && (ld || (out_valid && !out_ready));
      if (ld) begin
        out_alu_result <= ld_res;
        out_val_rm <= ld_rm;
        out_dest <= ld_dest;
        {out_mem_r_en, out_mem_w_en, out_wb_en} <= ld_ctl;
      end
      br_taken <= accept && b_en;
      if (accept && b_en) br_addr <= pc + {{(XLEN-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
      if (sr_we) sr <= sr_d;
    end
endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: directed and randomized checks of exe_stage_pipe against a behavioural model.
module tb_exe_stage_pipe;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, mem_r_en, mem_w_en, wb_en, s_bit, b_en, imm;
  logic out_valid, out_ready, out_mem_r_en, out_mem_w_en, out_wb_en, br_taken;
  logic [3:0] exe_cmd, dest, out_dest, sr;
  logic [31:0] pc, val_rn, val_rm, out_alu_result, out_val_rm, br_addr;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  int n_cmp = 0, n_bad = 0;
  bit mv, mbr;
  logic [31:0] m_res, m_rm, mbr_addr;
  logic [3:0] m_dest, msr;
  logic [2:0] m_ctl;
  logic [3:0] cmds [12] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'hB, 4'hF};

  exe_stage_pipe #(.XLEN(32), .MUL_STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .s_bit(s_bit), .b_en(b_en), .dest(dest), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
    .out_val_rm(out_val_rm), .out_dest(out_dest), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en), .br_taken(br_taken),
    .br_addr(br_addr), .sr(sr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_val2(input logic im, input logic mem, input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] x;
    int sv, amt;
    amt = int'(so[11:7]);
    if (im) begin
      x = {24'h0, so[7:0]};
      for (int k = 0; k < 2 * int'(so[11:8]); k++) x = {x[0], x[31:1]};
      return x;
    end
    if (mem) return {20'h0, so};
    case (so[6:5])
      2'd0: return 32'(64'(rm) * (64'd1 << amt));
      2'd1: return rm / (32'd1 << amt);
      2'd2: begin sv = rm; return 32'(sv >>> amt); end
      default: begin
        x = rm;
        for (int k = 0; k < amt; k++) x = {x[0], x[31:1]};
        return x;
      end
    endcase
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] fl, output logic [31:0] r, output logic [3:0] nf, output bit kn);
    longint u, s, ci;
    bit c, v;
    kn = 1;
    c = fl[1];
    v = fl[0];
    r = 0;
    case (cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h2, 4'h3: begin
        ci = (cmd == 4'h3 && fl[1]) ? 1 : 0;
        u = longint'(a) + longint'(b) + ci;
        s = longint'(int'(a)) + longint'(int'(b)) + ci;
        r = u[31:0];
        c = u >= 64'sd4294967296;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'h4, 4'h5: begin
        ci = (cmd == 4'h5 && !fl[1]) ? 1 : 0;
        u = longint'(a) - longint'(b) - ci;
        s = longint'(int'(a)) - longint'(int'(b)) - ci;
        r = u[31:0];
        c = u >= 0;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      default: kn = 0;
    endcase
    nf = {r[31], r == 0, c, v};
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic im, input logic [11:0] so, input logic s, input logic [3:0] d);
    in_valid = 1; exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; shift_operand = so;
    s_bit = s; dest = d; wb_en = 1; mem_r_en = 0; mem_w_en = 0; b_en = 0; pc = 0;
    signed_imm_24 = 0; flush = 0;
  endtask

  // one clock: predict handshake at negedge, advance the model, compare just after the edge
  task automatic step();
    logic exp_ready, acc, kn;
    logic [31:0] v2, r;
    logic [3:0] f;
    @(negedge clk);
    exp_ready = !mv || out_ready;
    chk("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready && !flush;
    v2 = m_val2(imm, mem_r_en || mem_w_en, shift_operand, val_rm);
    m_alu(exe_cmd, val_rn, v2, msr, r, f, kn);
    if (flush) mv = 0;
    else if (acc) begin
      mv = 1; m_res = r; m_rm = val_rm; m_dest = dest;
      m_ctl = b_en ? 3'b000 : {mem_r_en, mem_w_en, wb_en};
    end else if (out_ready) mv = 0;
    mbr = acc && b_en;
    if (mbr) mbr_addr = pc + 32'(int'({{8{signed_imm_24[23]}}, signed_imm_24}) * 4);
    if (acc && s_bit && kn && !b_en) msr = f;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mv);
    chk("sr", sr, msr);
    chk("br_taken", br_taken, mbr);
    chk("br_addr", br_addr, mbr_addr);
    if (mv) begin
      chk("alu_result", out_alu_result, m_res);
      chk("val_rm", out_val_rm, m_rm);
      chk("dest", out_dest, m_dest);
      chk("ctl", {out_mem_r_en, out_mem_w_en, out_wb_en}, m_ctl);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; exe_cmd = 0; mem_r_en = 0; mem_w_en = 0;
    wb_en = 0; s_bit = 0; b_en = 0; dest = 0; pc = 0; val_rn = 0; val_rm = 0; imm = 0;
    shift_operand = 0; signed_imm_24 = 0;
    mv = 0; mbr = 0; msr = 0; mbr_addr = 0; m_res = 0; m_rm = 0; m_dest = 0; m_ctl = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sr", sr, 4'b0000);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_result", out_alu_result, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    drive(4'h2, 32'h7FFF_FFFF, 0, 1, 12'h001, 1, 4'd3);
    step();
    chk("add_ovf_res", out_alu_result, 32'h8000_0000);
    chk("add_ovf_sr", sr, 4'b1001);
    drive(4'h2, 32'd10, 0, 1, 12'h005, 0, 4'd1);
    step();
    out_ready = 0;
    drive(4'h2, 32'd20, 0, 1, 12'h007, 0, 4'd2);
    step();
    chk("bp_hold1", out_alu_result, 32'd15);
    step();
    chk("bp_hold2", out_alu_result, 32'd15);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    step();
    chk("bp_second", out_alu_result, 32'd27);
    drive(4'h2, 0, 0, 0, 12'h000, 0, 4'd2);
    b_en = 1; pc = 32'h100; signed_imm_24 = 24'hFFFFFE;
    step();
    chk("br_pulse", br_taken, 1);
    chk("br_target", br_addr, 32'hF8);
    chk("br_no_wb", out_wb_en, 0);
    in_valid = 0; b_en = 0;
    step();
    chk("br_one_cycle", br_taken, 0);
    drive(4'h2, 0, 0, 0, 12'h000, 0, 4'd2);
    b_en = 1; pc = 32'h200; flush = 1;
    step();
    chk("br_flushed", br_taken, 0);
    flush = 0; in_valid = 0; b_en = 0;
    step();
    drive(4'h4, 32'd5, 0, 1, 12'h002, 1, 4'd4);
    step();
    chk("sub_sr", sr, 4'b0010);
    drive(4'h3, 32'd1, 0, 1, 12'h001, 0, 4'd4);
    step();
    chk("adc_res", out_alu_result, 32'd3);
    drive(4'h2, 32'd1, 0, 1, 12'h001, 1, 4'd4);
    step();
    drive(4'h5, 32'd5, 0, 1, 12'h002, 0, 4'd4);
    step();
    chk("sbc_res", out_alu_result, 32'd2);
    drive(4'hB, 32'd5, 0, 1, 12'h003, 1, 4'd5);
    step();
    chk("unknown_res", out_alu_result, 0);
    chk("unknown_sr", sr, 4'b0000);
    drive(4'h1, 0, 32'h8000_0001, 0, 12'h240, 0, 4'd6);
    step();
    chk("asr_val2", out_alu_result, 32'hF800_0000);
    drive(4'h1, 0, 32'h8000_0001, 0, 12'h260, 0, 4'd6);
    step();
    chk("ror_val2", out_alu_result, 32'h1800_0000);
    drive(4'h1, 0, 0, 1, 12'h4FF, 0, 4'd6);
    step();
    chk("imm_rot", out_alu_result, 32'hFF00_0000);
`ifdef EXE_MUL_EN
    in_valid = 0;
    step();
    drive(4'hA, 32'd3, 32'd9, 1, 12'h005, 1, 4'd7);
    @(negedge clk);
    chk("mul_accept_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    for (int k = 0; k < 8; k++) begin
      chk("mul_busy_rdy", in_ready, 0);
      chk("mul_busy_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("mul_done_rdy", in_ready, 0);
    chk("mul_done_valid", out_valid, 0);
    @(posedge clk);
    #1;
    msr = {2'b00, msr[1:0]};
    chk("mul_valid", out_valid, 1);
    chk("mul_res", out_alu_result, 32'd15);
    chk("mul_sr", sr, msr);
    mv = 1; m_res = 32'd15; m_rm = 32'd9; m_dest = 4'd7; m_ctl = 3'b001; mbr = 0;
    drive(4'hA, 32'd3, 32'd9, 1, 12'h005, 1, 4'd7);
    @(posedge clk);
    #1;
    in_valid = 0;
    @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    for (int k = 0; k < 10; k++) begin
      chk("mulfl_valid", out_valid, 0);
      chk("mulfl_sr", sr, msr);
      @(posedge clk);
      #1;
    end
    chk("mulfl_rdy", in_ready, 1);
    mv = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      exe_cmd = cmds[$urandom_range(0, 11)];
`ifndef EXE_MUL_EN
      if ($urandom_range(0, 15) == 0) exe_cmd = 4'hA;
`endif
      b_en = $urandom_range(0, 7) == 0;
      s_bit = b_en ? 1'b0 : 1'($urandom_range(0, 1));
      mem_r_en = $urandom_range(0, 5) == 0;
      mem_w_en = !mem_r_en && $urandom_range(0, 5) == 0;
      wb_en = 1'($urandom_range(0, 1));
      imm = 1'($urandom_range(0, 1));
      shift_operand = 12'($urandom);
      val_rn = rnd32();
      val_rm = rnd32();
      pc = $urandom;
      signed_imm_24 = 24'($urandom);
      dest = 4'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
